multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/core_pkg.sv | 38 +++
 rtl/wait_timer.sv | 25 ++
 rtl/multicycle_controller.sv | 151 +++++++++++++++
 tb/tb_multicycle_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared opcode constants, FSM state encoding and decode helpers for the
// multicycle sequencer and the datapath/decoder that reuse them.
package core_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  function automatic logic opcode_legal(input logic [6:0] op, input logic jal_ok);
    case (op)
      OP_LOAD, OP_STORE, OP_ALU_R, OP_ALU_I, OP_BRANCH, OP_LUI: opcode_legal = 1'b1;
      OP_JAL:  opcode_legal = jal_ok;
      default: opcode_legal = 1'b0;
    endcase
  endfunction

  // Operand B comes from the immediate for everything except R-ALU and branch.
  function automatic logic uses_imm(input logic [6:0] op);
    case (op)
      OP_ALU_I, OP_LOAD, OP_STORE, OP_LUI, OP_JAL: uses_imm = 1'b1;
      default: uses_imm = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wait_timer.sv
// 8-bit handshake wait counter; expired is high while the count sits at limit.
module wait_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       tick,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (tick && (count_reg != 8'hFF)) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign expired = (count_reg == limit);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky
// TRAP for illegal opcodes and memory handshake timeouts.
module multicycle_controller
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int SUPPORT_JUMP   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  input  logic        dmem_ack,
  input  logic        branch_taken,
  output logic        reg_w_en,
  output logic        dmem_w_en,
  output logic        dmem_alu_sel,
  output logic        reg_imm_sel,
  output logic        ir_en,
  output logic        pc_en,
  output logic        pc_branch_sel,
  output logic        trap,
  output logic        bus_err,
  output logic [2:0]  state
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam logic       JAL_OK        = (SUPPORT_JUMP != 0);

  state_t     state_reg, state_next;
  logic [6:0] opcode_reg;
  logic [2:0] funct3_reg;
  logic       bus_err_reg, bus_err_next;
  logic       timer_clear, timer_tick, timer_expired;

  logic is_load, is_store, is_branch, is_jal;
  assign is_load   = (opcode_reg == OP_LOAD);
  assign is_store  = (opcode_reg == OP_STORE);
  assign is_branch = (opcode_reg == OP_BRANCH);
  assign is_jal    = (opcode_reg == OP_JAL);

  // funct3 is held for the datapath ALU decode; the sequencer never looks at it.
  logic unused_bits;
  assign unused_bits = ^{instr[31:15], instr[11:7], funct3_reg};

  wait_timer u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .tick    (timer_tick),
    .limit   (TIMEOUT_LIMIT),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_FETCH;
      opcode_reg  <= '0;
      funct3_reg  <= '0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bus_err_reg <= bus_err_next;
      if (ir_en) begin
        opcode_reg <= instr[6:0];
        funct3_reg <= instr[14:12];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus_err_next  = bus_err_reg;
    timer_clear   = 1'b0;
    timer_tick    = 1'b0;
    ir_en         = 1'b0;
    pc_en         = 1'b0;
    pc_branch_sel = 1'b0;
    imem_req      = (state_reg == ST_FETCH);
    dmem_req      = (state_reg == ST_MEM);
    dmem_w_en     = (state_reg == ST_MEM) && is_store;
    reg_w_en      = (state_reg == ST_WB);
    trap          = (state_reg == ST_TRAP);
    reg_imm_sel   = uses_imm(opcode_reg);
    dmem_alu_sel  = !is_load;

    case (state_reg)
      ST_FETCH: begin
        if (imem_ack) begin
          ir_en      = 1'b1;
          state_next = ST_DECODE;
        end else if (timer_expired) begin
          state_next   = ST_TRAP;
          bus_err_next = 1'b1;
        end else begin
          timer_tick = 1'b1;
        end
      end
      ST_DECODE: begin
        state_next = opcode_legal(opcode_reg, JAL_OK) ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        if (is_load || is_store) begin
          state_next  = ST_MEM;
          timer_clear = 1'b1;
        end else if (is_branch) begin
          state_next    = ST_FETCH;
          timer_clear   = 1'b1;
          pc_en         = 1'b1;
          pc_branch_sel = branch_taken;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (is_store) begin
            state_next  = ST_FETCH;
            timer_clear = 1'b1;
            pc_en       = 1'b1;
          end else begin
            state_next = ST_WB;
          end
        end else if (timer_expired) begin
          state_next   = ST_TRAP;
          bus_err_next = 1'b1;
        end else begin
          timer_tick = 1'b1;
        end
      end
      ST_WB: begin
        state_next    = ST_FETCH;
        timer_clear   = 1'b1;
        pc_en         = 1'b1;
        pc_branch_sel = is_jal;
      end
      ST_TRAP: begin
        state_next = ST_TRAP;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  assign bus_err = bus_err_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven scoreboard bench for multicycle_controller (TIMEOUT_CYCLES=4),
// plus hand-written reset and mid-MEM abort sequences.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        imem_req, imem_ack, dmem_req, dmem_ack, branch_taken;
  logic        reg_w_en, dmem_w_en, dmem_alu_sel, reg_imm_sel;
  logic        ir_en, pc_en, pc_branch_sel, trap, bus_err;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  multicycle_controller #(.TIMEOUT_CYCLES(4), .SUPPORT_JUMP(1)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken),
    .reg_w_en(reg_w_en), .dmem_w_en(dmem_w_en),
    .dmem_alu_sel(dmem_alu_sel), .reg_imm_sel(reg_imm_sel),
    .ir_en(ir_en), .pc_en(pc_en), .pc_branch_sel(pc_branch_sel),
    .trap(trap), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic        bt;
    int          id;    // imem ack delay in cycles (>=40 means never)
    int          dd;    // dmem ack delay in cycles
    int          cycles;
    int          irn;
    int          regw;
    int          dmw;
    int          dreq;
    int          pcn;
    logic        sel;
    logic        imm;
    logic        alu;
    logic        trp;
    logic        be;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(logic [31:0] ins, logic bt, int id, int dd, int cycles,
                              int irn, int regw, int dmw, int dreq, int pcn,
                              logic sel, logic imm, logic alu, logic trp, logic be);
    vec_t v;
    v.ins = ins; v.bt = bt; v.id = id; v.dd = dd; v.cycles = cycles;
    v.irn = irn; v.regw = regw; v.dmw = dmw; v.dreq = dreq; v.pcn = pcn;
    v.sel = sel; v.imm = imm; v.alu = alu; v.trp = trp; v.be = be;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    vec_t o, e;
    int   iw, dw;
    bit   done;
    o = mk(v.ins, v.bt, v.id, v.dd, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    iw = 0; dw = 0; done = 0;
    exp_q.push_back(v);
    instr = v.ins;
    branch_taken = v.bt;
    for (int c = 0; c < 40 && !done; c++) begin
      imem_ack = imem_req && (iw == v.id);
      dmem_ack = dmem_req && (dw == v.dd);
      @(negedge clk);
      o.cycles++;
      if (ir_en)     o.irn++;
      if (reg_w_en)  o.regw++;
      if (dmem_w_en) o.dmw++;
      if (dmem_req)  o.dreq++;
      if (state == 3'd1) begin
        o.imm = reg_imm_sel;
        o.alu = dmem_alu_sel;
      end
      if (reg_w_en && dmem_w_en) begin
        total++; bad++;
        $display("FAIL vec%0d wr_excl: reg_w_en and dmem_w_en both 1", n);
      end
      if (pc_en) begin
        o.pcn++;
        o.sel = pc_branch_sel;
        done = 1;
      end
      if (trap) begin
        o.trp = 1'b1;
        o.be  = bus_err;
        done  = 1;
      end
      if (imem_req && !imem_ack) iw++;
      if (dmem_req && !dmem_ack) dw++;
      @(posedge clk);
      #1;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL vec%0d timeout: no retire or trap within 40 cycles", n);
    end
    e = exp_q.pop_front();
    chk($sformatf("vec%0d cycles", n), o.cycles, e.cycles);
    chk($sformatf("vec%0d ir_en", n), o.irn, e.irn);
    chk($sformatf("vec%0d reg_w_en", n), o.regw, e.regw);
    chk($sformatf("vec%0d dmem_w_en", n), o.dmw, e.dmw);
    chk($sformatf("vec%0d dmem_req", n), o.dreq, e.dreq);
    chk($sformatf("vec%0d pc_en", n), o.pcn, e.pcn);
    chk($sformatf("vec%0d pc_branch_sel", n), o.sel, e.sel);
    chk($sformatf("vec%0d reg_imm_sel", n), o.imm, e.imm);
    chk($sformatf("vec%0d dmem_alu_sel", n), o.alu, e.alu);
    chk($sformatf("vec%0d trap", n), o.trp, e.trp);
    chk($sformatf("vec%0d bus_err", n), o.be, e.be);
    if (e.trp) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d trap_hold", n), trap, 1);
      chk($sformatf("vec%0d bus_err_hold", n), bus_err, e.be);
      chk($sformatf("vec%0d pc_en_in_trap", n), pc_en, 0);
      do_reset();
    end else begin
      chk($sformatf("vec%0d state_after", n), state, 0);
    end
    $display("vec%0d instr=%08h cycles=%0d regw=%0d dmw=%0d pc_en=%0d sel=%0d trap=%0d bus_err=%0d",
             n, v.ins, o.cycles, o.regw, o.dmw, o.pcn, o.sel, o.trp, o.be);
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;

    //             instr         bt id  dd  cyc ir rw dw dq pc sel  imm  alu  trp  be
    vecs.push_back(mk(32'h00208033, 0, 0,  0,  4, 1, 1, 0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)); // add
    vecs.push_back(mk(32'h0000A103, 0, 0,  3,  8, 1, 1, 0, 4, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)); // lw, late ack
    vecs.push_back(mk(32'h00112023, 0, 0,  0,  4, 1, 0, 1, 1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)); // sw
    vecs.push_back(mk(32'h00208463, 1, 0,  0,  3, 1, 0, 0, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)); // beq taken
    vecs.push_back(mk(32'h00208463, 0, 0,  0,  3, 1, 0, 0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)); // beq not taken
    vecs.push_back(mk(32'h00100093, 0, 2,  0,  6, 1, 1, 0, 0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)); // addi, slow fetch
    vecs.push_back(mk(32'h000010B7, 0, 0,  0,  4, 1, 1, 0, 0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)); // lui
    vecs.push_back(mk(32'h008000EF, 0, 0,  0,  4, 1, 1, 0, 0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)); // jal
    vecs.push_back(mk(32'h0000A103, 0, 0,  0,  5, 1, 1, 0, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)); // lw no stall
    vecs.push_back(mk(32'h00208033, 0, 4,  0,  8, 1, 1, 0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)); // ack at limit
    vecs.push_back(mk(32'h00112023, 0, 0,  4,  8, 1, 0, 5, 5, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)); // sw ack at limit
    vecs.push_back(mk(32'hFFFFFFFF, 0, 0,  0,  3, 1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)); // illegal
    vecs.push_back(mk(32'h00208033, 0, 99, 0,  6, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1)); // fetch timeout
    vecs.push_back(mk(32'h0000A103, 0, 0, 99,  9, 1, 0, 0, 5, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1)); // load timeout

    // Reset state
    #3;
    chk("rst state", state, 0);
    chk("rst trap", trap, 0);
    chk("rst bus_err", bus_err, 0);
    chk("rst reg_w_en", reg_w_en, 0);
    chk("rst dmem_w_en", dmem_w_en, 0);
    chk("rst dmem_req", dmem_req, 0);
    chk("rst pc_en", pc_en, 0);
    chk("rst ir_en", ir_en, 0);
    chk("rst reg_imm_sel", reg_imm_sel, 0);
    do_reset();
    @(negedge clk);
    chk("post_rst imem_req", imem_req, 1);
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset asserted while a store sits in MEM waiting for dmem_ack
    instr = 32'h00112023;
    imem_ack = 1'b1;
    @(posedge clk); #1 imem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mem_abort pre dmem_req", dmem_req, 1);
    chk("mem_abort pre dmem_w_en", dmem_w_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mem_abort dmem_req", dmem_req, 0);
    chk("mem_abort dmem_w_en", dmem_w_en, 0);
    chk("mem_abort state", state, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mem_abort release state", state, 0);
    chk("mem_abort release imem_req", imem_req, 1);
    chk("mem_abort release reg_w_en", reg_w_en, 0);
    $display("mem_abort sequence: state=%0d imem_req=%0d", state, imem_req);
    @(posedge clk); #1;
    run_vec(99, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
